// File: rtl/vec_reg_file_masked_pkg.sv
// Shared element/vector types and default geometry for the vector register file.
// Pure declarations; no logic, no latency, no flow control.
package vec_pkg;

    localparam int DEF_LANES = 16;
    localparam int DEF_N     = 16;
    localparam int DEF_NREGS = 16;

    typedef logic [DEF_N-1:0]     elem_t;
    typedef elem_t [DEF_LANES-1:0] vec_t;
    typedef logic [DEF_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/vec_reg_file_masked_if.sv
// Decode-side bundle of the vector register file: read/write ports plus issue/scoreboard.
// Reads and stall are combinational; no backpressure, decode holds on stall.
interface vec_reg_file_masked_if
    import vec_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int N     = DEF_N,
    parameter int NREGS = DEF_NREGS
);
    localparam int AW = $clog2(NREGS);

    logic                       we3;
    logic [LANES-1:0]           wmask;
    logic                       bcast;
    logic [AW-1:0]              ra1;
    logic [AW-1:0]              ra2;
    logic [AW-1:0]              ra3;
    logic [LANES-1:0][N-1:0]    wd3;
    logic [LANES-1:0][N-1:0]    rd1;
    logic [LANES-1:0][N-1:0]    rd2;
    logic                       iss_valid;
    logic [AW-1:0]              iss_rd;
    logic [NREGS-1:0]           busy;
    logic                       stall;
    logic [AW:0]                busy_cnt;

    modport master (
        output we3, wmask, bcast, ra1, ra2, ra3, wd3, iss_valid, iss_rd,
        input  rd1, rd2, busy, stall, busy_cnt
    );

    modport slave (
        input  we3, wmask, bcast, ra1, ra2, ra3, wd3, iss_valid, iss_rd,
        output rd1, rd2, busy, stall, busy_cnt
    );

endinterface

// File: rtl/vec_reg_file_masked_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on collision.
// busy/busy_cnt update on the clock edge; stall is combinational, no backpressure.
module vec_scoreboard #(
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3_i,
    input  logic [AW-1:0]    ra3_i,
    input  logic             iss_valid_i,
    input  logic [AW-1:0]    iss_rd_i,
    input  logic [AW-1:0]    ra1_i,
    input  logic [AW-1:0]    ra2_i,
    output logic [NREGS-1:0] busy_o,
    output logic [AW:0]      busy_cnt_o,
    output logic             stall_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             pend1, pend2;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (we3_i)
            busy_d[ra3_i] = 1'b0;
        if (iss_valid_i)
            busy_d[iss_rd_i] = 1'b1;
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++)
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // An operand being written back this cycle arrives via bypass, so it is not pending.
    assign pend1 = busy_q[ra1_i] & ~(we3_i & (ra3_i == ra1_i));
    assign pend2 = busy_q[ra2_i] & ~(we3_i & (ra3_i == ra2_i));

    assign stall_o    = pend1 | pend2;
    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/vec_reg_file_masked.sv
// Vector register file: 2 combinational read ports, 1 masked/broadcast write port with bypass.
// Zero-latency reads, writes land on the clock edge; stall from the scoreboard, no backpressure.
module vec_reg_file_masked
    import vec_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int N     = DEF_N,
    parameter int NREGS = DEF_NREGS
) (
    input  logic                   clk,
    input  logic                   reset,
    vec_reg_file_masked_if.slave   bus
);

    localparam int AW = $clog2(NREGS);

    typedef logic [N-1:0]       lane_t;
    typedef lane_t [LANES-1:0]  row_t;

    row_t mem_q [NREGS];
    row_t wval;
    row_t wr_row_d;
    logic hit1, hit2;

    // wr_row_d is the full post-write image of row ra3; it doubles as the bypass source.
    always_comb begin
        wval     = '0;
        wr_row_d = '0;
        for (int i = 0; i < LANES; i++) begin
            wval[i]     = bus.bcast ? bus.wd3[0] : bus.wd3[i];
            wr_row_d[i] = bus.wmask[i] ? wval[i] : mem_q[bus.ra3][i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                mem_q[r] <= '0;
        end else if (bus.we3) begin
            mem_q[bus.ra3] <= wr_row_d;
        end
    end

    assign hit1    = bus.we3 && (bus.ra1 == bus.ra3);
    assign hit2    = bus.we3 && (bus.ra2 == bus.ra3);
    assign bus.rd1 = hit1 ? wr_row_d : mem_q[bus.ra1];
    assign bus.rd2 = hit2 ? wr_row_d : mem_q[bus.ra2];

    vec_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .we3_i       (bus.we3),
        .ra3_i       (bus.ra3),
        .iss_valid_i (bus.iss_valid),
        .iss_rd_i    (bus.iss_rd),
        .ra1_i       (bus.ra1),
        .ra2_i       (bus.ra2),
        .busy_o      (bus.busy),
        .busy_cnt_o  (bus.busy_cnt),
        .stall_o     (bus.stall)
    );

endmodule

// File: tb/tb_vec_reg_file_masked.sv
// Scoreboard bench for vec_reg_file_masked: directed cases plus a randomised phase.
module tb_vec_reg_file_masked;
    import vec_pkg::*;

    localparam int LANES = 16;
    localparam int N     = 16;
    localparam int NREGS = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vec_reg_file_masked_if #(.LANES(LANES), .N(N), .NREGS(NREGS)) bus ();

    vec_reg_file_masked #(.LANES(LANES), .N(N), .NREGS(NREGS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {K_RD1, K_RD2, K_BUSY, K_CNT, K_STALL} kind_e;
    typedef struct {
        kind_e        kind;
        string        tag;
        logic [255:0] val;
    } exp_t;

    exp_t             exp_q[$];
    vec_t             m_mem [NREGS];
    logic [NREGS-1:0] m_busy;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] observe(input kind_e k);
        case (k)
            K_RD1:   return bus.rd1;
            K_RD2:   return bus.rd2;
            K_BUSY:  return 256'(bus.busy);
            K_CNT:   return 256'(bus.busy_cnt);
            default: return 256'(bus.stall);
        endcase
    endfunction

    task automatic expect_val(input kind_e k, input string tag, input logic [255:0] v);
        exp_t e;
        e.kind = k;
        e.tag  = tag;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    function automatic vec_t model_rd(input logic [AW-1:0] ra);
        vec_t v;
        v = m_mem[ra];
        if (bus.we3 && ra == bus.ra3)
            for (int i = 0; i < LANES; i++)
                if (bus.wmask[i])
                    v[i] = bus.bcast ? bus.wd3[0] : bus.wd3[i];
        return v;
    endfunction

    function automatic logic model_pend(input logic [AW-1:0] r);
        return m_busy[r] && !(bus.we3 && bus.ra3 == r);
    endfunction

    task automatic push_model();
        expect_val(K_RD1,   "rd1",      model_rd(bus.ra1));
        expect_val(K_RD2,   "rd2",      model_rd(bus.ra2));
        expect_val(K_BUSY,  "busy",     256'(m_busy));
        expect_val(K_CNT,   "busy_cnt", 256'($countones(m_busy)));
        expect_val(K_STALL, "stall",    256'(model_pend(bus.ra1) || model_pend(bus.ra2)));
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_eq(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic model_update();
        if (reset) begin
            for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
            m_busy = '0;
        end else begin
            if (bus.we3) begin
                for (int i = 0; i < LANES; i++)
                    if (bus.wmask[i])
                        m_mem[bus.ra3][i] = bus.bcast ? bus.wd3[0] : bus.wd3[i];
                m_busy[bus.ra3] = 1'b0;
            end
            if (bus.iss_valid)
                m_busy[bus.iss_rd] = 1'b1;
        end
    endtask

    task automatic step();
        push_model();
        @(negedge clk);
        drain();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset         = 1'b0;
        bus.we3       = 1'b0;
        bus.wmask     = '0;
        bus.bcast     = 1'b0;
        bus.ra1       = '0;
        bus.ra2       = '0;
        bus.ra3       = '0;
        bus.wd3       = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
    endtask

    vec_t exp_v;

    initial begin
        idle();
        reset = 1'b1;
        for (int r = 0; r < NREGS; r++) m_mem[r] = '0;
        m_busy = '0;
        @(posedge clk);
        #1;
        step();

        // Reset state across all addresses
        for (int a = 0; a < NREGS; a++) begin
            idle();
            bus.ra1 = 4'(a);
            bus.ra2 = 4'(NREGS - 1 - a);
            expect_val(K_RD1, "rst_rd1", '0);
            expect_val(K_RD2, "rst_rd2", '0);
            expect_val(K_STALL, "rst_stall", '0);
            step();
        end
        expect_val(K_BUSY, "rst_busy", '0);
        expect_val(K_CNT, "rst_cnt", '0);
        step();

        // Lane-masked write
        idle();
        bus.we3 = 1'b1; bus.ra3 = 4'd5; bus.wmask = 16'h00FF;
        for (int i = 0; i < LANES; i++) bus.wd3[i] = 16'(i + 1);
        step();
        idle();
        bus.ra1 = 4'd5;
        exp_v = '0;
        for (int i = 0; i < 8; i++) exp_v[i] = 16'(i + 1);
        expect_val(K_RD1, "mask_write", exp_v);
        step();

        // Broadcast write uses lane 0 only
        idle();
        bus.we3 = 1'b1; bus.ra3 = 4'd2; bus.wmask = 16'hF000; bus.bcast = 1'b1;
        for (int i = 0; i < LANES; i++) bus.wd3[i] = 16'h5555;
        bus.wd3[0] = 16'hABCD;
        step();
        idle();
        bus.ra2 = 4'd2;
        exp_v = '0;
        for (int i = 12; i < 16; i++) exp_v[i] = 16'hABCD;
        expect_val(K_RD2, "bcast_write", exp_v);
        step();

        // Same-cycle bypass on both ports
        idle();
        bus.we3 = 1'b1; bus.ra3 = 4'd3; bus.wmask = 16'hFFFF;
        for (int i = 0; i < LANES; i++) bus.wd3[i] = 16'd7;
        bus.ra1 = 4'd3; bus.ra2 = 4'd3;
        for (int i = 0; i < LANES; i++) exp_v[i] = 16'd7;
        expect_val(K_RD1, "bypass_rd1", exp_v);
        expect_val(K_RD2, "bypass_rd2", exp_v);
        step();

        // Issue -> stall, writeback clears stall in the same cycle
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd4;
        step();
        idle();
        bus.ra1 = 4'd4;
        expect_val(K_STALL, "iss_stall", 256'(1));
        expect_val(K_BUSY, "iss_busy", 256'(16'h0010));
        expect_val(K_CNT, "iss_cnt", 256'(1));
        step();
        idle();
        bus.we3 = 1'b1; bus.ra3 = 4'd4; bus.ra1 = 4'd4;
        expect_val(K_STALL, "wb_nostall", '0);
        step();
        idle();
        expect_val(K_BUSY, "wb_cleared", '0);
        expect_val(K_CNT, "wb_cnt", '0);
        step();

        // Set wins over clear on the same register
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd6;
        step();
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd6;
        bus.we3 = 1'b1; bus.ra3 = 4'd6;
        step();
        idle();
        expect_val(K_BUSY, "set_wins", 256'(16'h0040));
        expect_val(K_CNT, "set_wins_cnt", 256'(1));
        step();

        // Reset overrides concurrent issue and write
        idle();
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd9;
        step();
        idle();
        reset = 1'b1;
        bus.iss_valid = 1'b1; bus.iss_rd = 4'd3;
        bus.we3 = 1'b1; bus.ra3 = 4'd5; bus.wmask = 16'hFFFF;
        for (int i = 0; i < LANES; i++) bus.wd3[i] = 16'h1234;
        step();
        idle();
        expect_val(K_BUSY, "rst_mid_busy", '0);
        expect_val(K_CNT, "rst_mid_cnt", '0);
        step();
        for (int a = 0; a < NREGS; a++) begin
            idle();
            bus.ra1 = 4'(a);
            expect_val(K_RD1, "rst_mid_rd", '0);
            step();
        end

        // Randomised traffic against the model
        for (int c = 0; c < 300; c++) begin
            idle();
            reset         = ($urandom_range(0, 39) == 0);
            bus.we3       = 1'($urandom_range(0, 1));
            bus.wmask     = 16'($urandom);
            bus.bcast     = ($urandom_range(0, 3) == 0);
            bus.ra3       = 4'($urandom_range(0, NREGS - 1));
            bus.ra1       = ($urandom_range(0, 2) == 0) ? bus.ra3 : 4'($urandom_range(0, NREGS - 1));
            bus.ra2       = ($urandom_range(0, 3) == 0) ? bus.ra1 : 4'($urandom_range(0, NREGS - 1));
            for (int i = 0; i < LANES; i++) bus.wd3[i] = 16'($urandom);
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rd    = ($urandom_range(0, 3) == 0) ? bus.ra3 : 4'($urandom_range(0, NREGS - 1));
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_reg_file_masked.md
Name: vec_reg_file_masked

Overview:
Parametrised next-generation vector register file for the decode stage of the vectorial CPU.
- NREGS vector registers, each LANES elements of N bits.
- Two combinational read ports and one write port with per-lane write mask and scalar-broadcast mode.
- Write-to-read bypass, so decode sees writeback data in the same cycle.
- Per-register busy scoreboard that drives a decode stall.

Parameters:
LANES, 16, elements per vector register
N, 16, bits per element
NREGS, 16, number of vector registers (power of two, >=2)
AW, $clog2(NREGS), register address width (derived localparam, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
we3  in  1  write enable, writeback port
wmask  in  LANES  per-lane write enable; lane i written only if we3 & wmask[i]
bcast  in  1  1 = write wd3[0] into every masked lane; 0 = lane i takes wd3[i]
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
ra3  in  AW  write address
wd3  in  LANES x N  write data (packed [LANES-1:0][N-1:0])
rd1  out  LANES x N  read data, port 1
rd2  out  LANES x N  read data, port 2
iss_valid  in  1  instruction issued this cycle that will write iss_rd
iss_rd  in  AW  destination register of issued instruction
busy  out  NREGS  scoreboard: register has an outstanding producer
stall  out  1  source operand (ra1 or ra2) still pending
busy_cnt  out  AW+1  number of set busy bits

Behaviour:
- Reset (synchronous, active-high): all registers cleared to 0 in the cycle reset is sampled; busy = 0; busy_cnt = 0. While reset is high, writes and issues are ignored.
- After reset: rd1 = rd2 = 0 and stall = 0 for any address.
- Write: at the rising edge with we3 = 1, for each lane i with wmask[i] = 1, reg[ra3][i] <= (bcast ? wd3[0] : wd3[i]). Unmasked lanes are unchanged.
- we3 = 1 with wmask = 0 is legal. No data changes, but the scoreboard still clears busy[ra3].
- Read: rd1/rd2 are combinational, zero latency.
- Bypass:
  - If we3 and ra1 == ra3, rd1 lane i = masked write value when wmask[i] = 1, else stored value. Same rule for rd2.
  - Both ports may bypass simultaneously; ra1 == ra2 is legal.
- Scoreboard update per edge:
  - we3 clears busy[ra3].
  - iss_valid sets busy[iss_rd].
  - Same register in the same cycle: set wins (new producer supersedes); busy stays 1.
  - Issue to an already-busy register leaves it 1. No counting of multiple producers; decode guarantees in-order single-writer.
- stall (combinational) = pend(ra1) | pend(ra2), where pend(r) = busy[r] & ~(we3 & ra3 == r). A value arriving via bypass does not stall.
- busy_cnt: registered popcount of the next busy vector, updated the same edge as busy; range 0..NREGS.
- Reset mid-operation: reset overrides concurrent we3 and iss_valid; all state cleared regardless.
- Address wrap: none; all AW-bit addresses are valid since NREGS is a power of two.

Decomposition:
- Package vec_pkg: LANES/N defaults, typedef elem_t (logic [N-1:0]), typedef vec_t (elem_t [LANES-1:0]), typedef lane_mask_t.
- Sub-module vec_scoreboard: busy vector, set/clear priority, busy_cnt, stall.
- The data array, mask/broadcast merge and bypass stay in the top module.

Test Plan:
- Reset then read all addresses -> rd1 = rd2 = 0, busy = 0, busy_cnt = 0, stall = 0.
- we3 = 1, ra3 = 5, wmask = 16'h00FF, bcast = 0, wd3 lane i = i+1; next cycle ra1 = 5 -> lanes 0..7 = 1..8, lanes 8..15 = 0.
- bcast = 1, wd3[0] = 16'hABCD, wmask = 16'hF000, ra3 = 2 -> reg2 lanes 12..15 = ABCD, others unchanged.
- Same-cycle write ra3 = 3 (wmask all 1, data 7) with ra1 = ra2 = 3 -> rd1 = rd2 = all 7 in that cycle.
- iss_valid, iss_rd = 4; next cycle ra1 = 4 -> stall = 1, busy[4] = 1, busy_cnt = 1. Then we3, ra3 = 4 -> stall = 0 that cycle; busy[4] = 0 next cycle.
- iss_valid & we3 both on register 6 (busy[6] = 1 beforehand) -> busy[6] stays 1. Assert reset with iss_valid = 1 -> busy = 0, register contents 0.
